// File: rtl/p66b_pkg.sv
// ---------------------------------------------------------------------------
// p66b_pkg
// Shared definitions for the 64b/66b receive gearbox and its block-lock FSM.
//   BLK_W / WORD_W : block and SERDES word widths
//   BUF_W          : residue buffer width (one block plus one word)
//   FILL_W         : width of the buffer fill level counter
//   SH_DATA/SH_CTRL: the two legal sync-header codes
//   lock_state_e   : block-lock FSM states
// ---------------------------------------------------------------------------
package p66b_pkg;

  localparam int BLK_W  = 66;
  localparam int WORD_W = 32;
  localparam int BUF_W  = BLK_W + WORD_W;
  localparam int FILL_W = $clog2(BUF_W);

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef enum logic {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } lock_state_e;

  // A sync header is legal only when its two bits differ.
  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/p66b_blklock.sv
// ---------------------------------------------------------------------------
// p66b_blklock
// Block-lock state machine: sync-header search while unlocked, windowed
// bad-header monitoring while locked.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   hdr_strobe       : a block header is being evaluated this cycle
//   hdr_valid        : that header is 01 or 10
//   slip_req         : drop one bit from the stream (same-cycle, Mealy)
//   locked           : registered lock indication
//   hdr_err          : invalid header seen while locked (same-cycle pulse)
// ---------------------------------------------------------------------------
module p66b_blklock
  import p66b_pkg::*;
#(
  parameter int LOCK_CNT  = 64,
  parameter int WINDOW    = 64,
  parameter int BAD_LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic hdr_strobe,
  input  logic hdr_valid,
  output logic slip_req,
  output logic locked,
  output logic hdr_err
);

  localparam int SH_MAX = (LOCK_CNT > WINDOW) ? LOCK_CNT : WINDOW;
  localparam int SH_W   = $clog2(SH_MAX + 1);
  localparam int BAD_W  = $clog2(BAD_LIMIT + 1);

  lock_state_e      state;
  logic [SH_W-1:0]  sh_cnt;
  logic [BAD_W-1:0] bad_cnt;
  logic [SH_W-1:0]  sh_inc;
  logic [BAD_W-1:0] bad_inc;

  // The slip must act on the very emission that exposed the bad header, so
  // slip_req is decoded from the registered state plus the current header
  // rather than registered itself.
  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    sh_inc   = sh_cnt + 1'b1;
    bad_inc  = bad_cnt + BAD_W'(!hdr_valid);
    slip_req = 1'b0;
    if (hdr_strobe) begin
      if (state == LK_UNLOCKED) slip_req = !hdr_valid;
      else                      slip_req = (bad_inc == BAD_W'(BAD_LIMIT));
    end
  end

  assign hdr_err = hdr_strobe && !hdr_valid && (state == LK_LOCKED);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= LK_UNLOCKED;
      locked  <= 1'b0;
      sh_cnt  <= '0;
      bad_cnt <= '0;
    end else if (hdr_strobe) begin
      case (state)
        LK_UNLOCKED: begin
          if (!hdr_valid) begin
            sh_cnt <= '0;
          end else if (sh_inc == SH_W'(LOCK_CNT)) begin
            state   <= LK_LOCKED;
            locked  <= 1'b1;
            sh_cnt  <= '0;
            bad_cnt <= '0;
          end else begin
            sh_cnt <= sh_inc;
          end
        end
        LK_LOCKED: begin
          // Too many bad headers outranks the window rollover.
          if (bad_inc == BAD_W'(BAD_LIMIT)) begin
            state   <= LK_UNLOCKED;
            locked  <= 1'b0;
            sh_cnt  <= '0;
            bad_cnt <= '0;
          end else if (sh_inc == SH_W'(WINDOW)) begin
            sh_cnt  <= '0;
            bad_cnt <= '0;
          end else begin
            sh_cnt  <= sh_inc;
            bad_cnt <= bad_inc;
          end
        end
        default: begin
          state   <= LK_UNLOCKED;
          locked  <= 1'b0;
          sh_cnt  <= '0;
          bad_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/p66brxgears.sv
// ---------------------------------------------------------------------------
// p66brxgears
// Receive gearbox: packs one 32-bit SERDES word per clock into 66-bit blocks
// (LSB first) and performs sync-header block lock with single-bit slips.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_data[31:0]     : received word, bit 0 earliest on the wire, every cycle
//   M_VALID          : M_DATA carries a new block this cycle (no backpressure)
//   M_DATA[65:0]     : block, [1:0] is the sync header
//   o_locked         : block lock achieved
//   o_hdr_errs[7:0]  : invalid headers seen while locked, saturating
// Build option:
//   P66BRXGEARS_HDRERR_EN - when defined, o_hdr_errs is a live counter;
//                           otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module p66brxgears
  import p66b_pkg::*;
#(
  parameter int LOCK_CNT  = 64,
  parameter int WINDOW    = 64,
  parameter int BAD_LIMIT = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [WORD_W-1:0] i_data,
  output logic              M_VALID,
  output logic [BLK_W-1:0]  M_DATA,
  output logic              o_locked,
  output logic [7:0]        o_hdr_errs
);

  logic [BUF_W-1:0]  buffer;
  logic [BUF_W-1:0]  full;
  logic [BUF_W-1:0]  buffer_nxt;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] total;
  logic [FILL_W-1:0] fill_nxt;
  logic              slip_pend;
  logic              slip_pend_nxt;
  logic              emit;
  logic              hdr_valid;
  logic              slip_req;
  logic              take_slip;
  logic              hdr_err;

  // Gearbox next-state. A slip is folded into the emission shift (67 bits)
  // when at least one residue bit is available; with an exactly empty
  // residue it is parked in slip_pend and taken from the next word.
  // A request arriving while a slip is already parked merges with it.
  always_comb begin
    full          = buffer | (BUF_W'(i_data) << fill);
    total         = fill + FILL_W'(WORD_W);
    emit          = (total >= FILL_W'(BLK_W));
    hdr_valid     = sh_is_valid(full[1:0]);
    take_slip     = slip_req | slip_pend;
    buffer_nxt    = full;
    fill_nxt      = total;
    slip_pend_nxt = 1'b0;
    if (emit) begin
      if (take_slip && (total > FILL_W'(BLK_W))) begin
        buffer_nxt = full >> (BLK_W + 1);
        fill_nxt   = total - FILL_W'(BLK_W + 1);
      end else begin
        buffer_nxt    = full >> BLK_W;
        fill_nxt      = total - FILL_W'(BLK_W);
        slip_pend_nxt = take_slip;
      end
    end else if (slip_pend) begin
      buffer_nxt = full >> 1;
      fill_nxt   = total - FILL_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      // NOTE: buffer must come out of reset as zero: new words are OR-merged
      // above the fill point, so stale upper bits would corrupt blocks.
      buffer    <= '0;
      fill      <= '0;
      slip_pend <= 1'b0;
      M_VALID   <= 1'b0;
      M_DATA    <= '0;
    end else begin
      buffer    <= buffer_nxt;
      fill      <= fill_nxt;
      slip_pend <= slip_pend_nxt;
      M_VALID   <= emit;
      if (emit) M_DATA <= full[BLK_W-1:0];
    end
  end

  p66b_blklock #(
    .LOCK_CNT (LOCK_CNT),
    .WINDOW   (WINDOW),
    .BAD_LIMIT(BAD_LIMIT)
  ) u_blklock (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .hdr_strobe(emit),
    .hdr_valid (hdr_valid),
    .slip_req  (slip_req),
    .locked    (o_locked),
    .hdr_err   (hdr_err)
  );

`ifdef P66BRXGEARS_HDRERR_EN
  logic [7:0] hdr_err_cnt;

  // Saturating; cleared only by reset so it accumulates across lock losses.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hdr_err_cnt <= '0;
    end else if (hdr_err && (hdr_err_cnt != 8'hFF)) begin
      hdr_err_cnt <= hdr_err_cnt + 8'd1;
    end
  end

  assign o_hdr_errs = hdr_err_cnt;
`else
  logic unused_hdr_err;
  assign unused_hdr_err = hdr_err;
  assign o_hdr_errs     = '0;
`endif

endmodule

// File: doc/p66brxgears.md
Name: p66brxgears

Overview:
- Receive-side gearbox: accepts one 32-bit word per clock from the SERDES and reassembles 66-bit blocks, LSB-first, for the 64b/66b decoder.
- Performs block lock using IEEE 802.3 Cl.49-style sync-header search with single-bit slips.
- Sits between the transceiver RX parallel output and the 66b descrambler/decoder. It is the inverse of the TX gearbox.

Parameters:
- LOCK_CNT, 64: consecutive valid headers required to declare lock.
- WINDOW, 64: header window size while locked.
- BAD_LIMIT, 16: invalid headers within WINDOW that drop lock.

Ports:
- i_clk  input  1  clock
- i_reset_n  input  1  asynchronous, active-low reset
- i_data  input  32  received word; bit 0 is the earliest bit on the wire; valid every cycle
- M_VALID  output  1  M_DATA holds a new block this cycle; no backpressure
- M_DATA  output  66  block; [1:0] is the sync header
- o_locked  output  1  block lock achieved
- o_hdr_errs  output  8  invalid-header count; see Optional Feature

Behaviour:
- Reset (async assert, sync release): M_VALID=0, M_DATA=0, o_locked=0, o_hdr_errs=0, fill=0, buffer=0, all counters and pending flags cleared.
- Each cycle:
  - full = buffer | (i_data << fill); total = fill + 32. buffer is 98 bits; fill range is 0..65.
  - If total >= 66: next cycle M_VALID=1 and M_DATA=full[65:0]; buffer <= full >> 66; fill <= total - 66.
  - Otherwise: M_VALID=0, M_DATA holds its value, buffer <= full, fill <= total.
- Latency: block is registered and appears the cycle after the word that completes it. Steady state gives 16 blocks per 33 cycles.
- Header check: performed on full[1:0] at emission. Valid iff the two bits differ (01 or 10).
- Slip: discard one bit from the stream.
  - Applied at emission when total >= 67: buffer <= full >> 67, fill <= total - 67.
  - If total == 66, set slip_pend. The slip is applied on the next cycle: buffer <= full >> 1, fill <= total - 1, or at the 67-bit shift if that cycle also emits.
  - Only one slip may be outstanding. A new slip request while slip_pend is set is ignored.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED, valid header: sh_cnt++. On reaching LOCK_CNT, go to LOCKED and clear sh_cnt and bad_cnt.
  - UNLOCKED, invalid header: slip; clear sh_cnt.
  - LOCKED, any header: sh_cnt++. An invalid header also increments bad_cnt.
  - LOCKED, bad_cnt reaches BAD_LIMIT: go to UNLOCKED, slip, clear both counters. This takes priority over window end.
  - LOCKED, sh_cnt reaches WINDOW with bad_cnt < BAD_LIMIT: clear both counters and stay LOCKED.
- o_locked == (state == LOCKED), registered.
- M_VALID is asserted for every emitted block regardless of lock state; downstream qualifies blocks with o_locked.
- Slips never stall input; the block following a slip emits on its natural schedule.

Optional Feature:
- Macro P66BRXGEARS_HDRERR_EN.
- Defined: o_hdr_errs counts invalid headers seen while LOCKED. It saturates at 255 and clears only on reset.
- Undefined: o_hdr_errs is tied to 0 and no counter logic is synthesized.

Decomposition:
- Package p66b_pkg holds:
  - constants SH_DATA=2'b01 and SH_CTRL=2'b10;
  - localparams BLK_W=66 and WORD_W=32;
  - lock FSM state enum.
- Sub-module p66b_blklock: lock FSM and counters.
  - Inputs: hdr_strobe, hdr_valid.
  - Outputs: slip request, locked, hdr_err pulse.
- The gearbox datapath stays in p66brxgears.

Test Plan:
1. Aligned stream of 66b blocks with alternating SH_DATA/SH_CTRL, fill starting at 0 -> M_VALID exactly 16 times per 33 cycles; M_DATA equals the sent blocks; o_locked rises the cycle after the 64th header.
2. Stream offset by 5 bits -> one slip per invalid header until aligned. Lock is declared after 64 consecutive valid headers following the last slip; all subsequent M_DATA bit-exact.
3. Locked, inject 15 bad headers within one 64-header window -> o_locked stays 1. Inject 16 -> o_locked falls on the 16th, one slip occurs, then relock after realignment.
4. Slip request when total == 66 -> slip_pend set, bit dropped next cycle; output alignment equals the slip-at-67 case.
5. Assert i_reset_n low mid-block asynchronously -> M_VALID=0 and o_locked=0 immediately. After release, first emission occurs 3 cycles later (fill 0 -> 32 -> 64 -> 96).
6. With P66BRXGEARS_HDRERR_EN, locked, inject 3 bad headers -> o_hdr_errs=3. After 300 bad headers -> o_hdr_errs=255. Without the macro -> o_hdr_errs=0.
